conv33_mac: RTL and testbench



---
 rtl/conv33_pkg.sv | 34 +++
 rtl/conv33_adder_tree.sv | 36 +++
 rtl/conv33_mac.sv | 130 +++++++++++++
 tb/tb_conv33_mac.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv33_pkg.sv
// Shared constants and the requantise helper for the conv33 datapath
// (conv33_mac and the future pooling / FC stages).
package conv33_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int KERNEL_TAPS    = 9;

  // Requantise works on a fixed wide type so any ACC_WIDTH up to 63 fits
  // with headroom for the rounding increment.
  localparam int RQ_W = 64;

  localparam logic signed [RQ_W-1:0] SAT_MAX_DEF = 64'sd127;
  localparam logic signed [RQ_W-1:0] SAT_MIN_DEF = -64'sd128;

  // Round-half-up arithmetic shift, optional ReLU, then clamp to dw bits.
  function automatic logic signed [RQ_W-1:0] requant(
    input logic signed [RQ_W-1:0] acc,
    input int                     shift,
    input int                     dw,
    input logic                   relu
  );
    logic signed [RQ_W-1:0] r, hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    else           r = acc;
    if (relu && (r < 64'sd0)) r = '0;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv33_adder_tree.sv
// S2: sums KERNEL_TAPS signed products into one registered, sign-extended
// accumulator-width value. Shared with the depthwise variant.
module conv33_adder_tree
  import conv33_pkg::*;
#(
  parameter int TAPS   = KERNEL_TAPS,
  parameter int PROD_W = 2 * DATA_WIDTH_DEF,
  parameter int SUM_W  = ACC_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [TAPS-1:0][PROD_W-1:0]  prod,
  output logic                         out_valid,
  output logic signed [SUM_W-1:0]      sum
);

  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++)
      sum_c = sum_c + SUM_W'($signed(prod[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) sum <= sum_c;
    end
  end

endmodule

// File: rtl/conv33_mac.sv
// 3x3 window MAC: multiply (S1), adder tree (S2), channel accumulate (S3),
// requantise (S4). Optional feature macro: CONV33_MAC_RELU_EN.
module conv33_mac
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IN_CH      = 1,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        pix_0,
  input  logic [DATA_WIDTH-1:0]        pix_1,
  input  logic [DATA_WIDTH-1:0]        pix_2,
  input  logic [DATA_WIDTH-1:0]        pix_3,
  input  logic [DATA_WIDTH-1:0]        pix_4,
  input  logic [DATA_WIDTH-1:0]        pix_5,
  input  logic [DATA_WIDTH-1:0]        pix_6,
  input  logic [DATA_WIDTH-1:0]        pix_7,
  input  logic [DATA_WIDTH-1:0]        pix_8,
  input  logic [DATA_WIDTH-1:0]        weight_0,
  input  logic [DATA_WIDTH-1:0]        weight_1,
  input  logic [DATA_WIDTH-1:0]        weight_2,
  input  logic [DATA_WIDTH-1:0]        weight_3,
  input  logic [DATA_WIDTH-1:0]        weight_4,
  input  logic [DATA_WIDTH-1:0]        weight_5,
  input  logic [DATA_WIDTH-1:0]        weight_6,
  input  logic [DATA_WIDTH-1:0]        weight_7,
  input  logic [DATA_WIDTH-1:0]        weight_8,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [$clog2(IN_CH):0]       ch_idx
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(IN_CH) + 1;

`ifdef CONV33_MAC_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] pix_vec, wgt_vec;
  logic [KERNEL_TAPS-1:0][PW-1:0]         prod_q;
  logic [1:0]                             vld_pipe;
  logic signed [ACC_WIDTH-1:0]            bias_s1, bias_s2;
  logic                                   s2_vld;
  logic signed [ACC_WIDTH-1:0]            s2_sum;
  logic signed [ACC_WIDTH-1:0]            acc;
  logic                                   fin;
  logic signed [RQ_W-1:0]                 rq;

  assign pix_vec = {pix_8, pix_7, pix_6, pix_5, pix_4, pix_3, pix_2, pix_1, pix_0};
  assign wgt_vec = {weight_8, weight_7, weight_6, weight_5, weight_4,
                    weight_3, weight_2, weight_1, weight_0};
  assign vld_pipe[0] = in_valid;

  // S1: nine signed products; bias rides along so it is taken from the beat itself
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      prod_q      <= '0;
      bias_s1     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        for (int i = 0; i < KERNEL_TAPS; i++)
          prod_q[i] <= PW'($signed(pix_vec[i])) * PW'($signed(wgt_vec[i]));
        bias_s1 <= bias;
      end
    end
  end

  // S2
  conv33_adder_tree #(
    .TAPS   (KERNEL_TAPS),
    .PROD_W (PW),
    .SUM_W  (ACC_WIDTH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_pipe[1]),
    .prod      (prod_q),
    .out_valid (s2_vld),
    .sum       (s2_sum)
  );

  always_ff @(posedge clk) begin
    if (rst)              bias_s2 <= '0;
    else if (vld_pipe[1]) bias_s2 <= bias_s1;
  end

  // S3: channel accumulation; bubbles leave acc and ch_idx untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      ch_idx <= '0;
      fin    <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (s2_vld) begin
        acc <= ((ch_idx == '0) ? bias_s2 : acc) + s2_sum;
        if (ch_idx == CW'(IN_CH - 1)) begin
          ch_idx <= '0;
          fin    <= 1'b1;
        end else begin
          ch_idx <= ch_idx + CW'(1);
        end
      end
    end
  end

  // S4: requantise only on the completing beat; out_data holds between pulses
  assign rq = requant(RQ_W'(acc), SHIFT, DATA_WIDTH, RELU);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin;
      if (fin) out_data <= DATA_WIDTH'(rq);
    end
  end

endmodule

// File: tb/tb_conv33_mac.sv
// Directed bench for conv33_mac: four instances cover IN_CH/SHIFT variants.
module tb_conv33_mac;

  logic clk = 1'b0;
  logic rst;
  logic va, vb, vc, vd;
  logic signed [7:0]  px [9];
  logic signed [7:0]  wt [9];
  logic signed [31:0] bias;

  logic signed [7:0] a_data, b_data, c_data, d_data;
  logic              a_vld, b_vld, c_vld, d_vld;
  logic [0:0]        a_ch, d_ch;
  logic [2:0]        b_ch;
  logic [1:0]        c_ch;

  int checks = 0;
  int errs   = 0;

`ifdef CONV33_MAC_RELU_EN
  localparam int RELU = 1;
`else
  localparam int RELU = 0;
`endif

  always #5 clk = ~clk;

  conv33_mac #(.DATA_WIDTH(8), .IN_CH(1), .ACC_WIDTH(32), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(va),
    .pix_0(px[0]), .pix_1(px[1]), .pix_2(px[2]), .pix_3(px[3]), .pix_4(px[4]),
    .pix_5(px[5]), .pix_6(px[6]), .pix_7(px[7]), .pix_8(px[8]),
    .weight_0(wt[0]), .weight_1(wt[1]), .weight_2(wt[2]), .weight_3(wt[3]),
    .weight_4(wt[4]), .weight_5(wt[5]), .weight_6(wt[6]), .weight_7(wt[7]),
    .weight_8(wt[8]), .bias(bias),
    .out_data(a_data), .out_valid(a_vld), .ch_idx(a_ch));

  conv33_mac #(.DATA_WIDTH(8), .IN_CH(3), .ACC_WIDTH(32), .SHIFT(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb),
    .pix_0(px[0]), .pix_1(px[1]), .pix_2(px[2]), .pix_3(px[3]), .pix_4(px[4]),
    .pix_5(px[5]), .pix_6(px[6]), .pix_7(px[7]), .pix_8(px[8]),
    .weight_0(wt[0]), .weight_1(wt[1]), .weight_2(wt[2]), .weight_3(wt[3]),
    .weight_4(wt[4]), .weight_5(wt[5]), .weight_6(wt[6]), .weight_7(wt[7]),
    .weight_8(wt[8]), .bias(bias),
    .out_data(b_data), .out_valid(b_vld), .ch_idx(b_ch));

  conv33_mac #(.DATA_WIDTH(8), .IN_CH(2), .ACC_WIDTH(32), .SHIFT(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc),
    .pix_0(px[0]), .pix_1(px[1]), .pix_2(px[2]), .pix_3(px[3]), .pix_4(px[4]),
    .pix_5(px[5]), .pix_6(px[6]), .pix_7(px[7]), .pix_8(px[8]),
    .weight_0(wt[0]), .weight_1(wt[1]), .weight_2(wt[2]), .weight_3(wt[3]),
    .weight_4(wt[4]), .weight_5(wt[5]), .weight_6(wt[6]), .weight_7(wt[7]),
    .weight_8(wt[8]), .bias(bias),
    .out_data(c_data), .out_valid(c_vld), .ch_idx(c_ch));

  conv33_mac #(.DATA_WIDTH(8), .IN_CH(1), .ACC_WIDTH(32), .SHIFT(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(vd),
    .pix_0(px[0]), .pix_1(px[1]), .pix_2(px[2]), .pix_3(px[3]), .pix_4(px[4]),
    .pix_5(px[5]), .pix_6(px[6]), .pix_7(px[7]), .pix_8(px[8]),
    .weight_0(wt[0]), .weight_1(wt[1]), .weight_2(wt[2]), .weight_3(wt[3]),
    .weight_4(wt[4]), .weight_5(wt[5]), .weight_6(wt[6]), .weight_7(wt[7]),
    .weight_8(wt[8]), .bias(bias),
    .out_data(d_data), .out_valid(d_vld), .ch_idx(d_ch));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic signed [7:0] p, input logic signed [7:0] w);
    for (int i = 0; i < 9; i++) begin
      px[i] = p;
      wt[i] = w;
    end
  endtask

  // Three channel beats of pix=2, w=3, bias=10 on u_b: acc 172 -> 43
  task automatic run_b_scenario(input string tag);
    set_all(8'sd2, 8'sd3);
    bias = 10;
    vb = 1'b1;
    repeat (3) step();
    vb = 1'b0;
    step();
    chk({tag, "_ch_mid"}, 32'(b_ch), 2);
    chk({tag, "_vld_e4"}, 32'(b_vld), 0);
    step();
    chk({tag, "_vld_e5"}, 32'(b_vld), 0);
    step();
    chk({tag, "_vld"}, 32'(b_vld), 1);
    chk({tag, "_data"}, b_data, 43);
    chk({tag, "_ch_wrap"}, 32'(b_ch), 0);
    step();
    chk({tag, "_pulse_end"}, 32'(b_vld), 0);
  endtask

  initial begin
    int nb;
    int beats [4] = '{0, 3, 4, 9};
    rst = 1'b1;
    va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0;
    set_all(8'sd0, 8'sd0);
    bias = 0;
    repeat (3) step();
    chk("rst_a_data", a_data, 0);
    chk("rst_a_vld", 32'(a_vld), 0);
    chk("rst_b_ch", 32'(b_ch), 0);
    chk("rst_b_vld", 32'(b_vld), 0);
    chk("rst_c_ch", 32'(c_ch), 0);
    rst = 1'b0;
    step();

    // single channel, all ones -> 9 at T+4 only
    set_all(8'sd1, 8'sd1);
    va = 1'b1;
    step();
    va = 1'b0;
    step(); chk("s1_vld_t2", 32'(a_vld), 0);
    step(); chk("s1_vld_t3", 32'(a_vld), 0);
    step(); chk("s1_vld_t4", 32'(a_vld), 1); chk("s1_data", a_data, 9);
    step(); chk("s1_vld_t5", 32'(a_vld), 0); chk("s1_hold", a_data, 9);

    // tap ordering with signed weights: sum (i+1)*(i-4) = 60
    for (int i = 0; i < 9; i++) begin
      px[i] = 8'(i + 1);
      wt[i] = 8'(i - 4);
    end
    va = 1'b1;
    step();
    va = 1'b0;
    repeat (3) step();
    chk("taps_vld", 32'(a_vld), 1);
    chk("taps_data", a_data, 60);

    // saturation, back to back beats (II=1)
    set_all(8'sd127, 8'sd127);
    va = 1'b1;
    step();
    set_all(-8'sd128, 8'sd127);
    step();
    va = 1'b0;
    repeat (2) step();
    chk("sat_pos_vld", 32'(a_vld), 1);
    chk("sat_pos", a_data, 127);
    step();
    chk("sat_neg_vld", 32'(a_vld), 1);
    chk("sat_neg", a_data, RELU ? 0 : -128);

    // multi-channel with rounding
    run_b_scenario("mc");

    // bubbles on IN_CH=2; bias only taken from the first beat of each pair
    set_all(8'sd1, 8'sd1);
    for (int c = 0; c < 15; c++) begin
      vc = (c == 0 || c == 3 || c == 4 || c == 9);
      bias = (c < 3) ? 5 : (c == 3) ? 100 : (c < 9) ? -3 : 50;
      step();
      nb = 0;
      for (int k = 0; k < 4; k++) if (beats[k] + 3 <= c + 1) nb++;
      chk("bub_vld", 32'(c_vld), ((c + 1 == 7) || (c + 1 == 13)) ? 1 : 0);
      chk("bub_ch", 32'(c_ch), nb % 2);
      if (c + 1 == 7)  chk("bub_data1", c_data, 23);
      if (c + 1 == 13) chk("bub_data2", c_data, 15);
    end
    vc = 1'b0;

    // reset mid-accumulation
    set_all(8'sd2, 8'sd3);
    bias = 10;
    vb = 1'b1;
    step();
    vb = 1'b0;
    repeat (3) step();
    chk("rmid_ch_pre", 32'(b_ch), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_ch", 32'(b_ch), 0);
    chk("rmid_vld", 32'(b_vld), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rmid_quiet", 32'(b_vld), 0);
    end

    // rst and in_valid together: beat dropped
    rst = 1'b1;
    vb = 1'b1;
    step();
    rst = 1'b0;
    vb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rsim_ch", 32'(b_ch), 0);
      chk("rsim_vld", 32'(b_vld), 0);
    end
    run_b_scenario("post_rst");

    // negative and positive rounding on SHIFT=2
    set_all(8'sd0, 8'sd0);
    bias = -6;
    vd = 1'b1;
    step();
    bias = 6;
    step();
    vd = 1'b0;
    repeat (2) step();
    chk("nr_vld", 32'(d_vld), 1);
    chk("nr_neg", d_data, RELU ? 0 : -1);
    step();
    chk("nr_pos", d_data, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
